// File: rtl/enigma_pkg.sv
// Rotor wirings, notches, reflector and mod-26 helpers
// shared by the rotor cipher datapath.
package enigma_pkg;

    localparam int ALPHA = 26;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_Z = 8'h5A;

    typedef logic [4:0] sym_t;

    // Rows are rotors I..V
    localparam int FWD [5][ALPHA] = '{
        '{4,10,12,5,11,6,3,16,21,25,13,19,14,
          22,24,7,23,20,18,15,0,8,1,17,2,9},
        '{0,9,3,10,18,8,17,20,23,1,11,7,22,
          19,12,2,16,6,25,13,15,24,5,21,14,4},
        '{1,3,5,7,9,11,2,15,17,19,23,21,25,
          13,24,4,8,22,6,0,10,12,20,18,16,14},
        '{4,18,14,21,15,25,9,0,24,16,20,8,17,
          7,23,11,13,5,19,6,10,3,2,12,22,1},
        '{21,25,1,17,6,8,19,24,20,15,18,3,13,
          7,11,23,0,22,12,9,16,14,5,4,2,10}
    };

    localparam int INV [5][ALPHA] = '{
        '{20,22,24,6,0,3,5,15,21,25,1,4,2,
          10,12,19,7,23,18,11,17,8,13,16,14,9},
        '{0,9,15,2,25,22,17,11,5,1,3,10,14,
          19,24,20,16,6,4,13,7,23,12,8,21,18},
        '{19,0,6,1,15,2,18,3,16,4,20,5,21,
          13,25,7,24,8,23,9,22,11,17,10,14,12},
        '{7,25,22,21,0,17,19,13,11,6,20,15,23,
          16,2,4,9,12,1,18,10,3,24,14,8,5},
        '{16,2,24,11,23,22,4,13,5,19,25,14,18,
          12,21,9,20,3,10,6,8,0,17,15,7,1}
    };

    localparam int NOTCH [5] = '{16, 4, 21, 9, 25};

    localparam int REFLECT_B [ALPHA] = '{
        24,17,20,7,16,18,11,3,15,23,13,6,14,
        10,12,8,4,1,5,25,2,22,21,9,0,19
    };

    // Wheel order, fastest first: III, II, I, IV
    localparam int ROTOR_SEL [4] = '{2, 1, 0, 3};

    function automatic sym_t addMod(sym_t a, sym_t b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 6'd26) ? sym_t'(s - 6'd26) : sym_t'(s);
    endfunction

    function automatic sym_t subMod(sym_t a, sym_t b);
        return (a >= b) ? sym_t'(a - b) : sym_t'(a + 5'd26 - b);
    endfunction

    function automatic sym_t incMod(sym_t a);
        return (a == 5'd25) ? 5'd0 : sym_t'(a + 5'd1);
    endfunction

    function automatic sym_t fold(sym_t a);
        return (a >= 5'd26) ? sym_t'(a - 5'd26) : a;
    endfunction

endpackage

// File: rtl/rotor_stage.sv
// Single rotor: forward wiring on the way in, inverse
// wiring on the way back from the reflector.
module rotor_stage
    import enigma_pkg::*;
#(
    parameter int SEL = 0
) (
    input  logic [4:0] pos,
    input  logic [4:0] fwdIn,
    output logic [4:0] fwdOut,
    input  logic [4:0] bwdIn,
    output logic [4:0] bwdOut
);

    sym_t fwdTap;
    sym_t bwdTap;

    assign fwdTap = sym_t'(FWD[SEL][addMod(fwdIn, pos)]);
    assign bwdTap = sym_t'(INV[SEL][addMod(bwdIn, pos)]);

    assign fwdOut = subMod(fwdTap, pos);
    assign bwdOut = subMod(bwdTap, pos);

endmodule

// File: rtl/rotor_cipher_engine.sv
// Stepping rotor cipher with a single registered output
// stage and pass-through backpressure.
module rotor_cipher_engine
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS    = 3,
    parameter int PASS_NONALPHA = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [5*NUM_ROTORS-1:0] startPosition,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [7:0]              inChar,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [7:0]              outChar,
    output logic [5*NUM_ROTORS-1:0] position
);

    sym_t posQ    [NUM_ROTORS];
    sym_t stepped [NUM_ROTORS];
    sym_t fwd     [NUM_ROTORS+1];
    sym_t bwd     [NUM_ROTORS+1];

    logic [NUM_ROTORS-1:0] atNotch;
    logic [NUM_ROTORS-1:0] stepEn;

    logic isLetter;
    logic inXfer;

    assign inReady  = !reset && !load && (!outValid || outReady);
    assign inXfer   = inValid && inReady;
    assign isLetter = (inChar >= ASCII_A) && (inChar <= ASCII_Z);

    assign fwd[0] = sym_t'(inChar - ASCII_A);
    assign bwd[NUM_ROTORS] = sym_t'(REFLECT_B[fwd[NUM_ROTORS]]);

    for (genvar i = 0; i < NUM_ROTORS; i++) begin : gRotor
        assign atNotch[i] = posQ[i] == sym_t'(NOTCH[ROTOR_SEL[i]]);
        assign stepped[i] = stepEn[i] ? incMod(posQ[i]) : posQ[i];
        assign position[5*i +: 5] = posQ[i];

        // Middle wheel also kicks itself on (double step)
        if (i == 0) begin : gFast
            assign stepEn[i] = 1'b1;
        end else if (i == 1 && NUM_ROTORS >= 3) begin : gDouble
            assign stepEn[i] = atNotch[0] | atNotch[1];
        end else begin : gCarry
            assign stepEn[i] = atNotch[i-1];
        end

        rotor_stage #(
            .SEL (ROTOR_SEL[i])
        ) uStage (
            .pos    (stepped[i]),
            .fwdIn  (fwd[i]),
            .fwdOut (fwd[i+1]),
            .bwdIn  (bwd[i+1]),
            .bwdOut (bwd[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            outValid <= 1'b0;
            outChar  <= 8'h00;
            for (int i = 0; i < NUM_ROTORS; i++) begin
                posQ[i] <= 5'd0;
            end
        end else if (load) begin
            outValid <= 1'b0;
            for (int i = 0; i < NUM_ROTORS; i++) begin
                posQ[i] <= fold(startPosition[5*i +: 5]);
            end
        end else begin
            if (outReady) begin
                outValid <= 1'b0;
            end
            if (inXfer) begin
                if (isLetter) begin
                    outValid <= 1'b1;
                    outChar  <= {3'b000, bwd[0]} + ASCII_A;
                    for (int i = 0; i < NUM_ROTORS; i++) begin
                        posQ[i] <= stepped[i];
                    end
                end else if (PASS_NONALPHA != 0) begin
                    outValid <= 1'b1;
                    outChar  <= inChar;
                end
            end
        end
    end

endmodule

// File: tb/tb_rotor_cipher_engine.sv
// Scoreboard bench for rotor_cipher_engine: a 3-rotor pass-through
// instance plus a 1-rotor dropping instance.
module tb_rotor_cipher_engine;

    typedef struct {
        logic [7:0] exp;
        logic [7:0] plain;
        bit         exact;
        bit         capture;
    } sbEntry_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [14:0] startPosition = '0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [7:0]  inChar = 8'h00;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [7:0]  outChar;
    logic [14:0] position;

    logic        load1 = 1'b0;
    logic [4:0]  startPosition1 = '0;
    logic        inValid1 = 1'b0;
    logic        inReady1;
    logic [7:0]  inChar1 = 8'h00;
    logic        outValid1;
    logic        outReady1 = 1'b1;
    logic [7:0]  outChar1;
    logic [4:0]  position1;

    int checks = 0;
    int errors = 0;

    sbEntry_t   sb [$];
    sbEntry_t   ent;
    logic [7:0] cipherQ [$];

    logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    logic [7:0] bdzgo [5] = '{8'h42, 8'h44, 8'h5A, 8'h47, 8'h4F};

    always #5 clock = ~clock;

    rotor_cipher_engine #(
        .NUM_ROTORS    (3),
        .PASS_NONALPHA (1)
    ) u0 (
        .clock         (clock),
        .reset         (reset),
        .load          (load),
        .startPosition (startPosition),
        .inValid       (inValid),
        .inReady       (inReady),
        .inChar        (inChar),
        .outValid      (outValid),
        .outReady      (outReady),
        .outChar       (outChar),
        .position      (position)
    );

    rotor_cipher_engine #(
        .NUM_ROTORS    (1),
        .PASS_NONALPHA (0)
    ) u1 (
        .clock         (clock),
        .reset         (reset),
        .load          (load1),
        .startPosition (startPosition1),
        .inValid       (inValid1),
        .inReady       (inReady1),
        .inChar        (inChar1),
        .outValid      (outValid1),
        .outReady      (outReady1),
        .outChar       (outChar1),
        .position      (position1)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && outValid && outReady) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out actual=%0d required=none",
                         outChar);
            end else begin
                ent = sb.pop_front();
                if (ent.exact) begin
                    if (outChar !== ent.exp) begin
                        errors++;
                        $display("FAIL out_char actual=%0d required=%0d",
                                 outChar, ent.exp);
                    end
                end else begin
                    if (outChar < 8'h41 || outChar > 8'h5A ||
                        outChar == ent.plain) begin
                        errors++;
                        $display("FAIL cipher_char actual=%0d required=letter!=%0d",
                                 outChar, ent.plain);
                    end
                    if (ent.capture) cipherQ.push_back(outChar);
                end
            end
        end
    end

    task automatic sendChar(input logic [7:0] c, input logic [7:0] e,
                            input bit exact, input bit capture);
        int n;
        sbEntry_t s;
        n = 0;
        inValid = 1'b1;
        inChar  = c;
        @(negedge clock);
        while (!inReady && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!inReady) begin
            check("send_timeout", 0, 1);
        end else begin
            s.exp = e;
            s.plain = c;
            s.exact = exact;
            s.capture = capture;
            sb.push_back(s);
        end
        @(posedge clock);
        #1;
        inValid = 1'b0;
        check("latency", outValid, 1);
    endtask

    task automatic doLoad(input logic [14:0] sp);
        startPosition = sp;
        load = 1'b1;
        @(negedge clock);
        check("inReady_load", inReady, 0);
        @(posedge clock);
        #1;
        load = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        @(posedge clock);
        #1;
        @(negedge clock);
        check("inReady_reset", inReady, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_pos", position, 0);
        check("rst_outValid", outValid, 0);
        check("rst_outChar", outChar, 0);

        doLoad({5'd0, 5'd0, 5'd0});
        for (int i = 0; i < 5; i++) sendChar(8'h41, bdzgo[i], 1, 0);
        check("aaaaa_pos", position, {5'd0, 5'd0, 5'd5});
        drain();

        doLoad({5'd0, 5'd3, 5'd20});
        sendChar(8'h41, 8'h00, 0, 0);
        check("dstep_1", position, {5'd0, 5'd3, 5'd21});
        sendChar(8'h41, 8'h00, 0, 0);
        check("dstep_2", position, {5'd0, 5'd4, 5'd22});
        sendChar(8'h41, 8'h00, 0, 0);
        check("dstep_3", position, {5'd1, 5'd5, 5'd23});
        drain();

        cipherQ.delete();
        doLoad({5'd5, 5'd10, 5'd15});
        for (int i = 0; i < 5; i++) sendChar(hello[i], 8'h00, 0, 1);
        drain();
        check("cipher_len", cipherQ.size(), 5);
        doLoad({5'd5, 5'd10, 5'd15});
        for (int i = 0; i < 5; i++) begin
            if (i < cipherQ.size()) sendChar(cipherQ[i], hello[i], 1, 0);
        end
        drain();

        doLoad({5'd0, 5'd0, 5'd0});
        sendChar(8'h41, 8'h42, 1, 0);
        outReady = 1'b0;
        inValid  = 1'b1;
        inChar   = 8'h41;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("stall_inReady", inReady, 0);
            check("stall_outChar", outChar, 8'h42);
            check("stall_pos", position, 1);
        end
        @(posedge clock);
        #1;
        outReady = 1'b1;
        sendChar(8'h41, 8'h44, 1, 0);
        check("resume_pos", position, 2);

        sendChar(8'h21, 8'h21, 1, 0);
        check("bang_pos", position, 2);
        drain();

        startPosition = {5'd0, 5'd0, 5'd7};
        load    = 1'b1;
        inValid = 1'b1;
        inChar  = 8'h41;
        @(negedge clock);
        check("ldin_inReady", inReady, 0);
        @(posedge clock);
        #1;
        load    = 1'b0;
        inValid = 1'b0;
        check("ldin_pos", position, 7);
        check("ldin_outValid", outValid, 0);
        @(posedge clock);
        #1;
        check("ldin_noout", outValid, 0);

        outReady = 1'b0;
        inValid  = 1'b1;
        inChar   = 8'h5A;
        @(negedge clock);
        check("rstf_inReady", inReady, 1);
        @(posedge clock);
        #1;
        inValid = 1'b0;
        check("rstf_pending", outValid, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rstf_outValid", outValid, 0);
        check("rstf_outChar", outChar, 0);
        check("rstf_pos", position, 0);
        outReady = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        startPosition1 = 5'd31;
        load1 = 1'b1;
        @(posedge clock);
        #1;
        load1 = 1'b0;
        check("r1_load31", position1, 5);
        inValid1 = 1'b1;
        inChar1  = 8'h41;
        @(negedge clock);
        check("r1_inReady", inReady1, 1);
        @(posedge clock);
        #1;
        inValid1 = 1'b0;
        check("r1_outValid", outValid1, 1);
        check("r1_outChar", outChar1, 8'h55);
        check("r1_pos", position1, 6);
        inValid1 = 1'b1;
        inChar1  = 8'h21;
        @(negedge clock);
        check("r1_bang_ready", inReady1, 1);
        @(posedge clock);
        #1;
        inValid1 = 1'b0;
        check("r1_drop", outValid1, 0);
        check("r1_drop_pos", position1, 6);

        drain();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
